// File: rtl/dcs_pkg.sv
// Shared types, width helpers and default sizing for the DCS attention datapath.
// The token buffer uses the same defaults, so both blocks agree on matrix geometry.
package dcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MEAN,
    ST_MASK,
    ST_WEI,
    ST_DRAIN,
    ST_OUT
  } state_e;

  localparam int DCS_N_ROWS = 8;
  localparam int DCS_N_COLS = 16;
  localparam int DCS_DATA_W = 8;
  localparam int DCS_N_WVEC = 1;
  localparam int DCS_OUT_W  = 32;

  // Gram entry width: a sum of n_cols products of two data_w operands.
  function automatic int gw_f(input int data_w, input int n_cols);
    return 2 * data_w + $clog2(n_cols);
  endfunction

  // Smallest result width that cannot overflow: weight * Gram entry summed over n_rows.
  function automatic int ow_min_f(input int data_w, input int n_cols, input int n_rows);
    return 3 * data_w + $clog2(n_cols) + $clog2(n_rows);
  endfunction

endpackage

// File: rtl/dcs_mac_lane.sv
// One result lane: registered product stage, then an accumulate stage that only
// adds when the product stage held a real weight. clr zeroes the sum for the next vector.
module dcs_mac_lane
  import dcs_pkg::*;
#(
  parameter int DATA_W = DCS_DATA_W,
  parameter int GW     = gw_f(DCS_DATA_W, DCS_N_COLS),
  parameter int OUT_W  = DCS_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] w,
  input  logic [GW-1:0]     g,
  output logic [OUT_W-1:0]  acc
);

  localparam int PW = DATA_W + GW;

  logic [PW-1:0]    prod_q, prod_d;
  logic             pv_q, pv_d;
  logic [OUT_W-1:0] acc_q, acc_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prod_d = {{GW{1'b0}}, w} * {{DATA_W{1'b0}}, g};
    pv_d   = in_valid & ~clr;
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (pv_q) begin
      acc_d = acc_q + OUT_W'(prod_q);
    end
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= pv_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dcs_attn_engine.sv
// Streams A, builds G = A*A^T on the fly, masks rows against their mean, then
// applies N_WVEC weight vectors through N_ROWS MAC lanes and streams the results.
module dcs_attn_engine
  import dcs_pkg::*;
#(
  parameter int N_ROWS = DCS_N_ROWS,
  parameter int N_COLS = DCS_N_COLS,
  parameter int DATA_W = DCS_DATA_W,
  parameter int N_WVEC = DCS_N_WVEC,
  parameter int OUT_W  = DCS_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_bypass,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              busy
);

  localparam int GW = gw_f(DATA_W, N_COLS);
  localparam int RW = $clog2(N_ROWS);
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int MW = GW + RW;
  localparam int VW = (N_WVEC > 1) ? $clog2(N_WVEC) : 1;

  if (OUT_W < ow_min_f(DATA_W, N_COLS, N_ROWS)) begin : g_ow_check
    $error("dcs_attn_engine: OUT_W too narrow for DATA_W/N_COLS/N_ROWS");
  end

  state_e            state_q, state_d;
  logic              bypass_q, bypass_d;
  logic [RW:0]       cnt_q, cnt_d;       // row in LOAD/MASK, step in MEAN, weight index, output index
  logic [CW-1:0]     col_q, col_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [DATA_W-1:0] a_q [N_ROWS][N_COLS];
  logic [DATA_W-1:0] a_d [N_ROWS][N_COLS];
  logic [GW-1:0]     g_q [N_ROWS][N_ROWS];
  logic [GW-1:0]     g_d [N_ROWS][N_ROWS];
  logic [MW-1:0]     mean_q [N_ROWS];
  logic [MW-1:0]     mean_d [N_ROWS];
  logic              i_ready_q, i_ready_d, w_ready_q, w_ready_d;
  logic              o_valid_q, o_valid_d, busy_q, busy_d;

  logic [RW-1:0]       row;
  logic [2*DATA_W-1:0] gprod [N_ROWS];
  logic [GW-1:0]       lane_g [N_ROWS];
  logic [OUT_W-1:0]    lane_acc [N_ROWS];
  logic                lane_valid, lane_clr;
  logic                i_hs, w_hs, o_hs;

  assign row  = cnt_q[RW-1:0];
  assign i_hs = i_valid && i_ready_q;
  assign w_hs = w_valid && w_ready_q;
  assign o_hs = o_valid_q && o_ready;

  // One multiplier per earlier row: the new element times the same column of row k.
  always_comb begin
    for (int k = 0; k < N_ROWS; k++) begin
      gprod[k] = {{DATA_W{1'b0}}, ((k == int'(row)) ? i_data : a_q[k][col_q])}
               * {{DATA_W{1'b0}}, i_data};
    end
  end

  always_comb begin
    state_d    = state_q;
    bypass_d   = bypass_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    vec_d      = vec_q;
    a_d        = a_q;
    g_d        = g_q;
    mean_d     = mean_q;
    lane_valid = 1'b0;
    lane_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (i_hs) begin
          if (state_q == ST_IDLE) bypass_d = cfg_bypass;
          state_d = ST_LOAD;
          a_d[row][col_q] = i_data;
          for (int rr = 0; rr < N_ROWS; rr++) begin
            for (int k = 0; k <= rr; k++) begin
              if (rr == int'(row)) begin
                g_d[k][rr] = g_q[k][rr] + GW'(gprod[k]);
                g_d[rr][k] = g_q[rr][k] + GW'(gprod[k]);
              end
            end
          end
          if (col_q == CW'(N_COLS - 1)) begin
            col_d = '0;
            if (row == RW'(N_ROWS - 1)) begin
              cnt_d   = '0;
              state_d = ST_MEAN;
            end else begin
              cnt_d = cnt_q + (RW+1)'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_MEAN: begin
        // G is symmetric, so accumulating column k over all rows yields row k's sum.
        if (!cnt_q[RW]) begin
          for (int k = 0; k < N_ROWS; k++) mean_d[k] = mean_q[k] + MW'(g_q[row][k]);
          cnt_d = cnt_q + (RW+1)'(1);
        end else begin
          for (int k = 0; k < N_ROWS; k++) mean_d[k] = mean_q[k] >> RW;
          cnt_d   = '0;
          state_d = bypass_q ? ST_WEI : ST_MASK;
        end
      end
      ST_MASK: begin
        for (int k = 0; k < N_ROWS; k++) begin
          if (!(MW'(g_q[row][k]) > mean_q[row])) g_d[row][k] = '0;
        end
        if (row == RW'(N_ROWS - 1)) begin
          cnt_d   = '0;
          state_d = ST_WEI;
        end else begin
          cnt_d = cnt_q + (RW+1)'(1);
        end
      end
      ST_WEI: begin
        if (w_hs) begin
          lane_valid = 1'b1;
          if (row == RW'(N_ROWS - 1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + (RW+1)'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (o_hs) begin
          if (row == RW'(N_ROWS - 1)) begin
            cnt_d    = '0;
            lane_clr = 1'b1;
            if (vec_q != VW'(N_WVEC - 1)) begin
              vec_d   = vec_q + VW'(1);
              state_d = ST_WEI;
            end else begin
              vec_d   = '0;
              state_d = ST_IDLE;
              for (int r = 0; r < N_ROWS; r++) begin
                mean_d[r] = '0;
                for (int k = 0; k < N_ROWS; k++) g_d[r][k] = '0;
                for (int c = 0; c < N_COLS; c++) a_d[r][c] = '0;
              end
            end
          end else begin
            cnt_d = cnt_q + (RW+1)'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    i_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    w_ready_d = (state_d == ST_WEI);
    o_valid_d = (state_d == ST_OUT);
    busy_d    = (state_d != ST_IDLE);
  end

  // NOTE: the matrix stores are reset too, because G and mean accumulate with += from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bypass_q  <= 1'b0;
      cnt_q     <= '0;
      col_q     <= '0;
      vec_q     <= '0;
      i_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int r = 0; r < N_ROWS; r++) begin
        mean_q[r] <= '0;
        for (int k = 0; k < N_ROWS; k++) g_q[r][k] <= '0;
        for (int c = 0; c < N_COLS; c++) a_q[r][c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      bypass_q  <= bypass_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      vec_q     <= vec_d;
      i_ready_q <= i_ready_d;
      w_ready_q <= w_ready_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
      a_q       <= a_d;
      g_q       <= g_d;
      mean_q    <= mean_d;
    end
  end

  for (genvar i = 0; i < N_ROWS; i++) begin : g_lane
    assign lane_g[i] = g_q[i][row];
    dcs_mac_lane #(.DATA_W(DATA_W), .GW(GW), .OUT_W(OUT_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (lane_clr),
      .in_valid (lane_valid),
      .w        (w_data),
      .g        (lane_g[i]),
      .acc      (lane_acc[i])
    );
  end

  assign i_ready = i_ready_q;
  assign w_ready = w_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_valid_q ? lane_acc[row] : '0;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dcs_attn_engine.sv
// Directed bench for dcs_attn_engine (8x16, two weight vectors per matrix) with
// hand-computed expected results, backpressure, input gaps and a mid-load reset.
module tb_dcs_attn_engine;

  localparam int N_ROWS = 8;
  localparam int N_COLS = 16;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_bypass;
  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              o_valid;
  logic              o_ready;
  logic [OUT_W-1:0]  o_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  dcs_attn_engine #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DATA_W(DATA_W), .N_WVEC(2), .OUT_W(OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bypass (cfg_bypass),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A patterns: 0 all ones, 1 diagonal of 2, 2 all 255.
  function automatic logic [DATA_W-1:0] a_val(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd1;
      1:       return (r == c) ? 8'd2 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  // W patterns: 0 ones, 1 twos, 2 j+1, 3 all 255.
  function automatic logic [DATA_W-1:0] w_val(input int pat, input int j);
    case (pat)
      0:       return 8'd1;
      1:       return 8'd2;
      2:       return DATA_W'(j + 1);
      default: return 8'd255;
    endcase
  endfunction

  task automatic send_a(input int pat, input bit byp, input bit gaps, input int n);
    for (int e = 0; e < n; e++) begin
      bit took;
      int b;
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
        tick();
      end
      i_valid    = 1'b1;
      i_data     = a_val(pat, e / N_COLS, e % N_COLS);
      cfg_bypass = byp;
      took = 1'b0;
      b    = 0;
      while (!took && b < 100) begin
        took = i_ready;
        tick();
        b++;
      end
      check("i_handshake", took, 1);
    end
    i_valid = 1'b0;
  endtask

  task automatic send_w(input int pat, input bit gaps);
    for (int j = 0; j < N_ROWS; j++) begin
      bit took;
      int b;
      if (gaps && $urandom_range(0, 2) == 0) begin
        w_valid = 1'b0;
        tick();
      end
      w_valid = 1'b1;
      w_data  = w_val(pat, j);
      took = 1'b0;
      b    = 0;
      while (!took && b < 100) begin
        took = w_ready;
        tick();
        b++;
      end
      check("w_handshake", took, 1);
    end
    w_valid = 1'b0;
    check("lat_drain_ovalid", o_valid, 0);
    tick();
    check("lat_out_ovalid", o_valid, 1);
  endtask

  task automatic recv(input int base, input int step, input int stall_idx, input bit last);
    for (int idx = 0; idx < N_ROWS; idx++) begin
      int b;
      b = 0;
      while (!o_valid && b < 100) begin
        tick();
        b++;
      end
      check("o_valid", o_valid, 1);
      check("o_data", o_data, base + step * idx);
      if (idx == stall_idx) begin
        o_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_ovalid", o_valid, 1);
          check("stall_odata", o_data, base + step * idx);
        end
        o_ready = 1'b1;
      end
      tick();
    end
    check("o_valid_drop", o_valid, 0);
    check("busy_after_vec", busy, !last);
    if (last) check("i_ready_idle", i_ready, 1);
  endtask

  task automatic run(input int apat, input bit byp, input int wp1, input int wp2,
                     input int b1, input int s1, input int b2, input int s2,
                     input bit gaps, input int stall_idx);
    send_a(apat, byp, gaps, N_ROWS * N_COLS);
    send_w(wp1, gaps);
    recv(b1, s1, stall_idx, 1'b0);
    send_w(wp2, gaps);
    recv(b2, s2, -1, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_bypass = 1'b0;
    i_valid    = 1'b0;
    i_data     = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    o_ready    = 1'b0;
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_busy", busy, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_w_ready", w_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_i_ready", i_ready, 1);
    check("idle_busy", busy, 0);
    o_ready = 1'b1;

    // Ones, masked: every G entry equals its row mean, so everything is masked.
    run(0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, -1);
    // Ones, bypassed: w=1 gives 8*16, then w=2 gives 256.
    run(0, 1'b1, 0, 1, 128, 0, 256, 0, 1'b0, -1);
    // Diagonal 2, masked: G diag 4, mean 0, out = 4*(j+1).
    run(1, 1'b0, 2, 2, 4, 4, 4, 4, 1'b0, -1);
    // Full-scale: 255*255*16*255*8.
    run(2, 1'b1, 3, 3, 2122416000, 0, 2122416000, 0, 1'b0, -1);
    // Diagonal case again with input/weight gaps and a 3-cycle stall at idx 2.
    run(1, 1'b0, 2, 2, 4, 4, 4, 4, 1'b1, 2);

    // Reset in the middle of LOAD discards the partial matrix.
    send_a(0, 1'b1, 1'b0, 20);
    check("load_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_o_data", o_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_i_ready", i_ready, 0);
    check("mid_rst_w_ready", w_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run(0, 1'b1, 0, 1, 128, 0, 256, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
